// File: rtl/adder_bist_64b.sv
`timescale 1ns/1ps
// adder_bist_64b
// Synthesizable self-test engine for a WIDTH-bit adder under test.
// Launches one operand pair per cycle (4 directed pairs, then two Galois
// LFSR streams). Checks each returned sum against a native '+' reference
// LAT edges later. Counts mismatches (saturating) and keeps the first
// failing vector.
module adder_bist_64b #(
  parameter int               WIDTH       = 64,
  parameter int               NUM_VECTORS = 100000,
  parameter int               LAT         = 1,
  parameter int               CNT_W       = 32,
  parameter logic [WIDTH-1:0] SEED_A      = 64'h0123456789ABCDEF,
  parameter logic [WIDTH-1:0] SEED_B      = 64'hFEDCBA9876543210
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH:0]   dut_s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] error_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_s
);

  localparam int VC_W = $clog2(NUM_VECTORS + 1);
  localparam int DC_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  localparam logic [VC_W-1:0]  LAST_IDX       = VC_W'(NUM_VECTORS - 1);
  localparam logic [VC_W-1:0]  FIRST_LFSR_IDX = VC_W'(4);
  localparam logic [DC_W-1:0]  DRAIN_LAST     = DC_W'(LAT);
  // Feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting Galois).
  localparam logic [WIDTH-1:0] TAPS     = {5'b11011, {(WIDTH-5){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALT_01   = {(WIDTH/2){2'b01}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One Galois LFSR step: shift right, fold the tap mask in when a 1 leaves.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] nxt;
    nxt = s >> 1;
    if (s[0]) begin
      nxt = nxt ^ TAPS;
    end
    return nxt;
  endfunction

  // Reference sum including carry-out.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  state_t           state;
  state_t           state_next;
  logic             enter_run;
  logic             launch;
  logic [VC_W-1:0]  vec_cnt;
  logic [DC_W-1:0]  drain_cnt;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             mismatch;

  // Check pipeline: stage j holds the vector launched j-1 edges ago.
  logic [WIDTH:0]   exp_p [1:LAT];
  logic [WIDTH-1:0] a_p   [1:LAT];
  logic [WIDTH-1:0] b_p   [1:LAT];
  logic             vld_p [1:LAT];

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign mismatch = vld_p[LAT] && (dut_s != exp_p[LAT]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the run-entry and launch strobes.
  always_comb begin
    state_next = state;
    enter_run  = 1'b0;
    launch     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          enter_run  = 1'b1;
        end
      end
      S_RUN: begin
        launch = 1'b1;
        if (vec_cnt == LAST_IDX) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // LAT edges for the last vector to reach the checker, one more to report.
        if (drain_cnt == DRAIN_LAST) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand selection: directed corner vectors first, LFSR streams afterwards.
  always_comb begin
    vec_a = lfsr_a;
    vec_b = lfsr_b;
    case (vec_cnt)
      VC_W'(0): begin vec_a = '0;       vec_b = '0;       end
      VC_W'(1): begin vec_a = ALL_ONES; vec_b = ONE;      end
      VC_W'(2): begin vec_a = ALL_ONES; vec_b = ALL_ONES; end
      VC_W'(3): begin vec_a = ALT_01;   vec_b = ~ALT_01;  end
      default: ;
    endcase
  end

  // Vector counter, LFSRs and the registered operand outputs.
  // The LFSR state itself is vector 4; it steps after each LFSR launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
      dut_a   <= '0;
      dut_b   <= '0;
    end else if (enter_run) begin
      vec_cnt <= '0;
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
    end else if (launch) begin
      dut_a   <= vec_a;
      dut_b   <= vec_b;
      vec_cnt <= vec_cnt + VC_W'(1);
      if (vec_cnt >= FIRST_LFSR_IDX) begin
        lfsr_a <= lfsr_step(lfsr_a);
        lfsr_b <= lfsr_step(lfsr_b);
      end
    end
  end

  // Edges spent in DRAIN; wraps harmlessly on the edge that leaves DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + DC_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // ---- stage boundary: launch -> check pipeline (LAT deep) ----
  // Expected sums and operands travel alongside the DUT's own latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j <= LAT; j++) begin
        exp_p[j] <= '0;
        a_p[j]   <= '0;
        b_p[j]   <= '0;
        vld_p[j] <= 1'b0;
      end
    end else begin
      vld_p[1] <= launch;
      exp_p[1] <= ref_sum(vec_a, vec_b);
      a_p[1]   <= vec_a;
      b_p[1]   <= vec_b;
      for (int j = 2; j <= LAT; j++) begin
        vld_p[j] <= vld_p[j-1];
        exp_p[j] <= exp_p[j-1];
        a_p[j]   <= a_p[j-1];
        b_p[j]   <= b_p[j-1];
      end
    end
  end

  // ---- stage boundary: check -> result registers ----
  // Count every mismatch, keep only the first failing vector of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_count <= '0;
      fail_valid  <= 1'b0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_s      <= '0;
    end else if (enter_run) begin
      error_count <= '0;
      fail_valid  <= 1'b0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_s      <= '0;
    end else if (mismatch) begin
      error_count <= sat_inc(error_count);
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= a_p[LAT];
        fail_b     <= b_p[LAT];
        fail_s     <= dut_s;
      end
    end
  end

endmodule

// File: doc/adder_bist_64b.md
# adder_bist_64b

On-chip self-test engine for the prefix-adder family: it drives operand pairs into an adder under test (DUT) and checks every sum against a native `+` reference. It also counts mismatches and captures the first failing vector. It sits beside a BrentKung64b-class adder on the FPGA, replacing the simulation-only bench flow with a synthesizable stimulus/checker. It is run from a start pulse and reports through done/error outputs.

## Interface
- WIDTH, 64, operand width; DUT sum is WIDTH+1 bits
- NUM_VECTORS, 100000, vectors per run (>= 4)
- LAT, 1, clock edges from operand launch to sum sampling (>= 1)
- CNT_W, 32, error counter width
- SEED_A, 64'h0123456789ABCDEF, nonzero LFSR seed for A
- SEED_B, 64'hFEDCBA9876543210, nonzero LFSR seed for B
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled only in IDLE or DONE
- dut_a  out  WIDTH  operand A to DUT (registered)
- dut_b  out  WIDTH  operand B to DUT (registered)
- dut_s  in  WIDTH+1  DUT sum
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE, held until next start or reset
- error_count  out  CNT_W  mismatches this run, saturating
- fail_valid  out  1  a mismatch has been captured this run
- fail_a, fail_b  out  WIDTH  operands of first mismatch
- fail_s  out  WIDTH+1  DUT sum of first mismatch

## Operation
- Reset: state IDLE, every output 0, LFSRs loaded with SEED_A/SEED_B, vector counter 0, expected/valid pipeline cleared.
- FSM: IDLE -start-> RUN; RUN -after NUM_VECTORS launches-> DRAIN; DRAIN -after LAT edges-> DONE; DONE -start-> RUN. start in RUN/DRAIN ignored.
- Entry into RUN (from IDLE or DONE): reseed LFSRs, clear counter, error_count, fail_* and fail_valid; done drops. Identical runs produce identical vectors.
- Each RUN edge launches one vector onto dut_a/dut_b and pushes expected = {1'b0,a}+{1'b0,b} (WIDTH+1 bits) with valid into a LAT-deep pipeline.
- Vector index 0..3 directed: (0,0); (all-ones,1); (all-ones,all-ones); (0x5555..55,0xAAAA..AA). Index >= 4: Galois LFSR outputs, polynomial x^64+x^63+x^61+x^60+1, advanced once per launch from index 4 on.
- Check: when pipeline valid reaches stage LAT, compare dut_s to expected (full WIDTH+1 bits, carry-out included). Mismatch: error_count += 1 saturating at 2^CNT_W-1; if fail_valid=0, latch operands and dut_s into fail_*, set fail_valid.
- dut_a/dut_b hold last vector in DRAIN/DONE/IDLE.
- Reset mid-run: immediate abort to reset values; done never asserts for aborted run.

## Timing
- start seen at edge E: RUN from E; vector k launched at edge E+1+k, k=0..N-1.
- Vector k compared at edge E+1+k+LAT.
- busy high after edge E through edge E+N+LAT; done high after edge E+N+LAT+1, busy low same edge; error_count final at that point.
- Throughput one vector per cycle; no backpressure.
- start high in DONE restarts at that edge; done falls at same edge.

## Test plan
- Ideal combinational DUT model, N=16, LAT=1, start at edge E -> done rises after edge E+18, error_count=0, fail_valid=0; dut_a/dut_b show the 4 directed vectors first.
- DUT with sum bit 64 stuck-0 -> first fail at vector 1: fail_a=all-ones, fail_b=1, fail_s=0, fail_valid=1, error_count>=2 (vector 2 also fails).
- Always-wrong DUT (s = a+b+1), CNT_W=4, N=20 -> error_count saturates at 15, fail_* = (0,0,1).
- rst_n low mid-RUN -> all outputs 0 asynchronously, state IDLE; later start gives a full clean run.
- start pulses during RUN ignored; restart from DONE reproduces identical dut_a/dut_b sequence and error_count.
- 3-stage registered adder model with LAT=3 -> 0 errors; same model with LAT=2 -> nonzero error_count.
